adder_bist: RTL and testbench
=============================

# adder_bist

Synthesizable built-in self-test engine for the combinational adder. It acts as the initiator side of the adder interface: it drives operands `a`/`b`, samples the sum `c`, and compares `c` against its own reference sum. It sits beside the adder in hardware, so the adder can be checked without the class-based generator/scoreboard bench. It runs a deterministic vector sequence, counts mismatches and latches the first failing vector.

## Interface
- `WIDTH`, 4: operand width; the sum `c` is `WIDTH+1` bits.
- `NUM_VECTORS`, 16: vectors per run; legal range 1..65535.
- `SEED`, 1: initial value of `b` (taken mod 2^WIDTH).

- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a run; sampled only in IDLE or DONE.
- `a`  out  WIDTH  operand A to the adder, registered.
- `b`  out  WIDTH  operand B to the adder, registered.
- `c`  in  WIDTH+1  sum returned by the adder (combinational path from `a`/`b`).
- `busy`  out  1  run in progress (DRIVE or SAMPLE).
- `done`  out  1  run complete; held until the next start or `rst`.
- `pass`  out  1  valid while `done`=1; 1 when zero mismatches occurred.
- `err_count`  out  16  number of mismatches; saturates at 16'hFFFF.
- `vec_count`  out  16  number of vectors compared so far in this run.
- `fail_valid`  out  1  set when the first mismatch is captured.
- `fail_a`, `fail_b`  out  WIDTH  operands of the first mismatching vector.

## Operation
- FSM states: IDLE, DRIVE, SAMPLE, DONE.
- **IDLE**: when `start`=1, go to DRIVE. On that same edge:
  - `a`←0, `b`←SEED;
  - clear `err_count`, `vec_count`, `fail_*`, `pass`, `done`.
- **DRIVE**: one settling cycle with operands stable; go to SAMPLE unconditionally.
- **SAMPLE**: compare `c` against `exp = {1'b0,a} + {1'b0,b}` (full WIDTH+1-bit compare).
  - On mismatch: increment `err_count` (saturating). If `fail_valid`=0, latch `fail_a`←`a`, `fail_b`←`b`, `fail_valid`←1.
  - `vec_count`←`vec_count`+1.
  - If this was vector NUM_VECTORS-1: go to DONE, `pass`←(no mismatch this run, including the current compare).
  - Otherwise: go to DRIVE with `a`←`a`+1 and `b`←`b`+3, both wrapping mod 2^WIDTH.
- **DONE**: `done`=1. `a`/`b` hold their last values. `start`=1 restarts exactly as from IDLE.
- `start` is ignored in DRIVE and SAMPLE.
- Vector k (0-based): `a` = k mod 2^WIDTH, `b` = (SEED + 3k) mod 2^WIDTH.

## Timing
- Reset values: `a`=0, `b`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `vec_count`=0, `fail_valid`=0, `fail_a`=0, `fail_b`=0. State is IDLE.
- `busy` = (state==DRIVE || state==SAMPLE), decoded from registered state.
- Two cycles per vector. If `start` is sampled at edge E0, `done` rises after edge E(2·NUM_VECTORS). Example: NUM_VECTORS=16 gives `done` after E32.
- The adder must settle within one clock period. `c` is sampled only at the SAMPLE-state edge, one full cycle after `a`/`b` change.
- `rst` has priority over everything, including mid-run. Next cycle: IDLE with all reset values, no `done`, and no partial result retained.
- `err_count`, `vec_count` and `fail_*` update on the same edge as the SAMPLE compare. On the final vector they are final on the edge `done` rises.
- `start` and `rst` both high: `rst` wins.

## Test plan
1. Correct adder, WIDTH=4, NUM_VECTORS=16, SEED=1, pulse `start` -> `done`=1 after 32 edges, `pass`=1, `err_count`=0, `vec_count`=16, `fail_valid`=0, final `a`=15, `b`=14.
2. Adder with `c[0]` stuck at 0, same parameters -> every sum 1+4k is odd, so `err_count`=16, `pass`=0, `fail_valid`=1, `fail_a`=0, `fail_b`=1.
3. Adder correct except when a=5 (vector 5: a=5, b=0, `c` forced to 6) -> `err_count`=1, `fail_a`=5, `fail_b`=0, `pass`=0.
4. `start` re-pulsed at cycles 3 and 10 of a run -> ignored, `done` still after edge 32. Then `start` in DONE -> `done`=0, counters cleared, new run completes 32 edges later with identical results.
5. `rst` asserted while `vec_count`=7 -> next cycle `busy`=0, `done`=0, `err_count`=0, `vec_count`=0, `a`=`b`=0. No `done` until a new `start`.
6. WIDTH=4, NUM_VECTORS=20, SEED=15, correct adder -> `a` wraps 15→0 and `b` wraps (15→2 at vector 1), `pass`=1, `vec_count`=20, `done` after 40 edges.

Source files
------------

// File: rtl/adder_bist.sv
`default_nettype none
// ============================================================================
//  Module      : adder_bist
//  Description : Built-in self-test engine for a combinational adder.
//                Drives a deterministic operand sequence, compares the
//                returned sum against a reference and records mismatches
//                and the first failing vector.
//  Revision    : 1.0 - initial release
// ============================================================================
module adder_bist #(
    parameter int WIDTH       = 4,
    parameter int NUM_VECTORS = 16,
    parameter int SEED        = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    input  logic [WIDTH:0]   c,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [15:0]      err_count,
    output logic [15:0]      vec_count,
    output logic             fail_valid,
    output logic [WIDTH-1:0] fail_a,
    output logic [WIDTH-1:0] fail_b
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DRIVE  = 2'd1;
    localparam logic [1:0] S_SAMPLE = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [WIDTH-1:0] C_SEED    = WIDTH'(SEED);
    localparam logic [WIDTH-1:0] C_A_STEP  = WIDTH'(1);
    localparam logic [WIDTH-1:0] C_B_STEP  = WIDTH'(3);
    localparam logic [15:0]      C_LAST    = 16'(NUM_VECTORS - 1);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_pass;
    logic [15:0]      r_err_count;
    logic [15:0]      r_vec_count;
    logic             r_fail_valid;
    logic [WIDTH-1:0] r_fail_a;
    logic [WIDTH-1:0] r_fail_b;

    logic             w_start_run;
    logic             w_sample;
    logic             w_last;
    logic [WIDTH:0]   w_exp;
    logic             w_mismatch;

    // Start is honoured only when no run is in flight.
    assign w_start_run = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_sample    = (r_state == S_SAMPLE);
    assign w_last      = (r_vec_count == C_LAST);
    assign w_exp       = {1'b0, r_a} + {1'b0, r_b};
    assign w_mismatch  = (c != w_exp);

    // Next-state decode for the run sequencer.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_start_run) w_state_nxt = S_DRIVE;
            S_DRIVE:  w_state_nxt = S_SAMPLE;
            S_SAMPLE: w_state_nxt = w_last ? S_DONE : S_DRIVE;
            S_DONE:   if (w_start_run) w_state_nxt = S_DRIVE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Operand generation, comparison bookkeeping and first-fail capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a          <= '0;
            r_b          <= '0;
            r_pass       <= 1'b0;
            r_err_count  <= '0;
            r_vec_count  <= '0;
            r_fail_valid <= 1'b0;
            r_fail_a     <= '0;
            r_fail_b     <= '0;
        end else if (w_start_run) begin
            r_a          <= '0;
            r_b          <= C_SEED;
            r_pass       <= 1'b0;
            r_err_count  <= '0;
            r_vec_count  <= '0;
            r_fail_valid <= 1'b0;
            r_fail_a     <= '0;
            r_fail_b     <= '0;
        end else if (w_sample) begin
            if (w_mismatch) begin
                if (r_err_count != 16'hFFFF) r_err_count <= r_err_count + 16'd1;
                if (!r_fail_valid) begin
                    r_fail_a     <= r_a;
                    r_fail_b     <= r_b;
                    r_fail_valid <= 1'b1;
                end
            end
            r_vec_count <= r_vec_count + 16'd1;
            if (w_last) begin
                // Any earlier mismatch leaves err_count non-zero (saturation never wraps to 0).
                r_pass <= (r_err_count == 16'd0) && !w_mismatch;
            end else begin
                r_a <= r_a + C_A_STEP;
                r_b <= r_b + C_B_STEP;
            end
        end
    end

    assign a          = r_a;
    assign b          = r_b;
    assign busy       = (r_state == S_DRIVE) || (r_state == S_SAMPLE);
    assign done       = (r_state == S_DONE);
    assign pass       = r_pass;
    assign err_count  = r_err_count;
    assign vec_count  = r_vec_count;
    assign fail_valid = r_fail_valid;
    assign fail_a     = r_fail_a;
    assign fail_b     = r_fail_b;

endmodule
`default_nettype wire

// File: tb/tb_adder_bist.sv
`default_nettype none
// ============================================================================
//  Module      : tb_adder_bist
//  Description : Directed self-checking bench for adder_bist, with a
//                behavioural adder that can inject sum faults.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_adder_bist;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance: WIDTH=4, NUM_VECTORS=16, SEED=1
    logic        rst, start;
    logic [3:0]  a, b, fail_a, fail_b;
    logic [4:0]  c;
    logic        busy, done, pass, fail_valid;
    logic [15:0] err_count, vec_count;
    int          fault_mode;

    // Second instance: WIDTH=4, NUM_VECTORS=20, SEED=15
    logic        rst6, start6;
    logic [3:0]  a6, b6, fail_a6, fail_b6;
    logic [4:0]  c6;
    logic        busy6, done6, pass6, fail_valid6;
    logic [15:0] err_count6, vec_count6;

    int checks   = 0;
    int failures = 0;

    // Adder model: 0 = correct, 1 = c[0] stuck at 0, 2 = c forced to 6 when a==5.
    always_comb begin
        c = {1'b0, a} + {1'b0, b};
        if (fault_mode == 1)                 c[0] = 1'b0;
        else if (fault_mode == 2 && a == 4'd5) c = 5'd6;
    end

    assign c6 = {1'b0, a6} + {1'b0, b6};

    adder_bist #(.WIDTH(4), .NUM_VECTORS(16), .SEED(1)) u_dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .c(c),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .vec_count(vec_count), .fail_valid(fail_valid),
        .fail_a(fail_a), .fail_b(fail_b)
    );

    adder_bist #(.WIDTH(4), .NUM_VECTORS(20), .SEED(15)) u_dut6 (
        .clk(clk), .rst(rst6), .start(start6), .a(a6), .b(b6), .c(c6),
        .busy(busy6), .done(done6), .pass(pass6), .err_count(err_count6),
        .vec_count(vec_count6), .fail_valid(fail_valid6),
        .fail_a(fail_a6), .fail_b(fail_b6)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Pulse start for one edge (E0) then count edges until done, bounded.
    task automatic start_and_wait(output int n);
        start = 1'b1;
        step;
        start = 1'b0;
        n = 0;
        while (!done && n < 100) begin
            step;
            n++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; rst6 = 1'b1; start = 1'b0; start6 = 1'b0; fault_mode = 0;
        step; step;
        rst = 1'b0; rst6 = 1'b0;
        checks++; if (a !== 4'd0)           begin failures++; $display("FAIL reset_a got=%0d exp=0", a); end
        checks++; if (b !== 4'd0)           begin failures++; $display("FAIL reset_b got=%0d exp=0", b); end
        checks++; if (busy !== 1'b0)        begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        checks++; if (done !== 1'b0)        begin failures++; $display("FAIL reset_done got=%0b exp=0", done); end
        checks++; if (pass !== 1'b0)        begin failures++; $display("FAIL reset_pass got=%0b exp=0", pass); end
        checks++; if (err_count !== 16'd0)  begin failures++; $display("FAIL reset_err got=%0d exp=0", err_count); end
        checks++; if (vec_count !== 16'd0)  begin failures++; $display("FAIL reset_vec got=%0d exp=0", vec_count); end
        checks++; if (fail_valid !== 1'b0)  begin failures++; $display("FAIL reset_fvalid got=%0b exp=0", fail_valid); end
        checks++; if (fail_a !== 4'd0 || fail_b !== 4'd0)
            begin failures++; $display("FAIL reset_fail_ab got=%0d/%0d exp=0/0", fail_a, fail_b); end
    endtask

    task automatic test_correct_adder;
        int n;
        fault_mode = 0;
        start = 1'b1;
        step;
        start = 1'b0;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL run_busy got=%0b exp=1", busy); end
        checks++; if (a !== 4'd0 || b !== 4'd1)
            begin failures++; $display("FAIL first_vec got=%0d/%0d exp=0/1", a, b); end
        n = 0;
        while (!done && n < 100) begin
            step;
            n++;
        end
        checks++; if (n !== 32)             begin failures++; $display("FAIL ok_latency got=%0d exp=32", n); end
        checks++; if (pass !== 1'b1)        begin failures++; $display("FAIL ok_pass got=%0b exp=1", pass); end
        checks++; if (err_count !== 16'd0)  begin failures++; $display("FAIL ok_err got=%0d exp=0", err_count); end
        checks++; if (vec_count !== 16'd16) begin failures++; $display("FAIL ok_vec got=%0d exp=16", vec_count); end
        checks++; if (fail_valid !== 1'b0)  begin failures++; $display("FAIL ok_fvalid got=%0b exp=0", fail_valid); end
        checks++; if (a !== 4'd15 || b !== 4'd14)
            begin failures++; $display("FAIL ok_final_ab got=%0d/%0d exp=15/14", a, b); end
        checks++; if (busy !== 1'b0)        begin failures++; $display("FAIL ok_busy_done got=%0b exp=0", busy); end
    endtask

    task automatic test_stuck_lsb;
        int n;
        fault_mode = 1;
        start_and_wait(n);
        checks++; if (n !== 32)             begin failures++; $display("FAIL stuck_latency got=%0d exp=32", n); end
        checks++; if (err_count !== 16'd16) begin failures++; $display("FAIL stuck_err got=%0d exp=16", err_count); end
        checks++; if (pass !== 1'b0)        begin failures++; $display("FAIL stuck_pass got=%0b exp=0", pass); end
        checks++; if (fail_valid !== 1'b1)  begin failures++; $display("FAIL stuck_fvalid got=%0b exp=1", fail_valid); end
        checks++; if (fail_a !== 4'd0 || fail_b !== 4'd1)
            begin failures++; $display("FAIL stuck_fail_ab got=%0d/%0d exp=0/1", fail_a, fail_b); end
    endtask

    task automatic test_single_fault;
        int n;
        fault_mode = 2;
        start_and_wait(n);
        checks++; if (err_count !== 16'd1)  begin failures++; $display("FAIL single_err got=%0d exp=1", err_count); end
        checks++; if (fail_a !== 4'd5 || fail_b !== 4'd0)
            begin failures++; $display("FAIL single_fail_ab got=%0d/%0d exp=5/0", fail_a, fail_b); end
        checks++; if (pass !== 1'b0)        begin failures++; $display("FAIL single_pass got=%0b exp=0", pass); end
        checks++; if (vec_count !== 16'd16) begin failures++; $display("FAIL single_vec got=%0d exp=16", vec_count); end
    endtask

    task automatic test_start_ignored_and_restart;
        int n;
        fault_mode = 0;
        start = 1'b1;
        step;
        start = 1'b0;
        n = 0;
        while (!done && n < 100) begin
            start = (n == 2 || n == 9);   // high across edges E3 and E10
            step;
            n++;
        end
        start = 1'b0;
        checks++; if (n !== 32)             begin failures++; $display("FAIL repulse_latency got=%0d exp=32", n); end
        checks++; if (pass !== 1'b1)        begin failures++; $display("FAIL repulse_pass got=%0b exp=1", pass); end
        // Restart from DONE
        start = 1'b1;
        step;
        start = 1'b0;
        checks++; if (done !== 1'b0)        begin failures++; $display("FAIL restart_done got=%0b exp=0", done); end
        checks++; if (vec_count !== 16'd0)  begin failures++; $display("FAIL restart_vec got=%0d exp=0", vec_count); end
        checks++; if (pass !== 1'b0)        begin failures++; $display("FAIL restart_pass_clr got=%0b exp=0", pass); end
        checks++; if (a !== 4'd0 || b !== 4'd1)
            begin failures++; $display("FAIL restart_ab got=%0d/%0d exp=0/1", a, b); end
        n = 0;
        while (!done && n < 100) begin
            step;
            n++;
        end
        checks++; if (n !== 32)             begin failures++; $display("FAIL restart_latency got=%0d exp=32", n); end
        checks++; if (pass !== 1'b1 || err_count !== 16'd0 || vec_count !== 16'd16)
            begin failures++; $display("FAIL restart_result got=p%0b e%0d v%0d exp=p1 e0 v16", pass, err_count, vec_count); end
    endtask

    task automatic test_reset_mid_run;
        int n;
        fault_mode = 1;   // make err_count non-zero before the reset
        start = 1'b1;
        step;
        start = 1'b0;
        n = 0;
        while (vec_count != 16'd7 && n < 100) begin
            step;
            n++;
        end
        checks++; if (vec_count !== 16'd7 || err_count !== 16'd7)
            begin failures++; $display("FAIL midrun_reach got=v%0d e%0d exp=v7 e7", vec_count, err_count); end
        rst = 1'b1;
        step;
        rst = 1'b0;
        checks++; if (busy !== 1'b0)        begin failures++; $display("FAIL midrst_busy got=%0b exp=0", busy); end
        checks++; if (done !== 1'b0)        begin failures++; $display("FAIL midrst_done got=%0b exp=0", done); end
        checks++; if (err_count !== 16'd0)  begin failures++; $display("FAIL midrst_err got=%0d exp=0", err_count); end
        checks++; if (vec_count !== 16'd0)  begin failures++; $display("FAIL midrst_vec got=%0d exp=0", vec_count); end
        checks++; if (a !== 4'd0 || b !== 4'd0)
            begin failures++; $display("FAIL midrst_ab got=%0d/%0d exp=0/0", a, b); end
        checks++; if (fail_valid !== 1'b0)  begin failures++; $display("FAIL midrst_fvalid got=%0b exp=0", fail_valid); end
        repeat (40) step;
        checks++; if (done !== 1'b0 || busy !== 1'b0)
            begin failures++; $display("FAIL midrst_idle got=d%0b b%0b exp=d0 b0", done, busy); end
        fault_mode = 0;
    endtask

    task automatic test_wrap_20_vectors;
        int n;
        start6 = 1'b1;
        step;
        start6 = 1'b0;
        checks++; if (a6 !== 4'd0 || b6 !== 4'd15)
            begin failures++; $display("FAIL wrap_first got=%0d/%0d exp=0/15", a6, b6); end
        n = 0;
        while (!done6 && n < 100) begin
            step;
            n++;
            if (n == 2) begin
                checks++; if (a6 !== 4'd1 || b6 !== 4'd2)
                    begin failures++; $display("FAIL wrap_vec1 got=%0d/%0d exp=1/2", a6, b6); end
            end
            if (n == 32) begin
                checks++; if (a6 !== 4'd0)
                    begin failures++; $display("FAIL wrap_a16 got=%0d exp=0", a6); end
            end
        end
        checks++; if (n !== 40)              begin failures++; $display("FAIL wrap_latency got=%0d exp=40", n); end
        checks++; if (pass6 !== 1'b1)        begin failures++; $display("FAIL wrap_pass got=%0b exp=1", pass6); end
        checks++; if (vec_count6 !== 16'd20) begin failures++; $display("FAIL wrap_vec got=%0d exp=20", vec_count6); end
        checks++; if (a6 !== 4'd3 || b6 !== 4'd8)
            begin failures++; $display("FAIL wrap_final_ab got=%0d/%0d exp=3/8", a6, b6); end
    endtask

    initial begin
        test_reset;
        test_correct_adder;
        test_stuck_lsb;
        test_single_fault;
        test_start_ignored_and_restart;
        test_reset_mid_run;
        test_wrap_20_vectors;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
